hazard_stall_controller: RTL and testbench

Sequencing controller for the 3-stage decode-info shift register (execute, memory access, writeback) and the register file writeback it feeds. It tracks destination registers of in-flight instructions in a scoreboard and detects read-after-write hazards at decode. It generates the 8-bit stall vector and the pipeline clear strobe, freezes on memory wait states, and sequences branch-mispredict flushes.

---
 rtl/hazard_stall_controller.sv | 139 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Read-after-write hazard detection, memory-wait freeze and branch-flush sequencing
// for a three-stage (EX/MEM/WB) decode-info pipeline.
module hazard_stall_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [2:0]       dec_src_a,
    input  logic             dec_src_a_used,
    input  logic [2:0]       dec_src_b,
    input  logic             dec_src_b_used,
    input  logic [2:0]       dec_dst,
    input  logic             dec_wr_dst,
    input  logic             dec_wr_src,
    input  logic             mem_busy,
    input  logic             branch_fail,
    output logic [7:0]       stall_out,
    output logic             clear_out,
    output logic             fetch_hold,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] dst;
        logic       wr_dst;
        logic [2:0] src;
        logic       wr_src;
    } sb_entry_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t    state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    sb_entry_t sb_q [3];
    logic [2:0] hazard;
    logic       freeze;

    // A source hits an entry if it is actually read and matches any register
    // that the in-flight instruction will write.
    function automatic logic src_hit(input sb_entry_t e, input logic [2:0] s, input logic used);
        return used && e.valid && ((e.wr_dst && (e.dst == s)) || (e.wr_src && (e.src == s)));
    endfunction

    always_comb begin
        hazard = '0;
        for (int k = 0; k < 3; k++) begin
            hazard[k] = src_hit(sb_q[k], dec_src_a, dec_src_a_used) |
                        src_hit(sb_q[k], dec_src_b, dec_src_b_used);
        end
    end

    assign freeze = (state_q == MEM_WAIT) || ((state_q == RUN) && mem_busy);

    // Decode handshake: the decode stage offers an instruction with dec_valid; it is
    // accepted into EX only on a non-frozen RUN cycle with stall_out[2:0]==0, otherwise
    // it must be held unchanged and re-presented.
    always_comb begin
        stall_out    = '0;
        stall_out[0] = dec_valid & hazard[0];
        stall_out[1] = dec_valid & hazard[1];
        stall_out[2] = dec_valid & hazard[2];
        stall_out[3] = freeze;
        stall_out[4] = (state_q == FLUSH);
    end

    assign clear_out  = (state_q == FLUSH);
    assign fetch_hold = (|stall_out) & ~branch_fail;
    assign state_o    = state_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (branch_fail) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (mem_busy) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (branch_fail) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (!mem_busy) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (branch_fail) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q == 4'd0) begin
                    state_d = mem_busy ? MEM_WAIT : RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_cnt_q  <= '0;
            stall_cycles <= '0;
            for (int k = 0; k < 3; k++) sb_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if ((|stall_out) && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if ((state_q == FLUSH) || branch_fail) begin
                for (int k = 0; k < 3; k++) sb_q[k].valid <= 1'b0;
            end else if (!freeze) begin
                // A stalled decode enters EX as a bubble.
                sb_q[2]        <= sb_q[1];
                sb_q[1]        <= sb_q[0];
                sb_q[0].valid  <= dec_valid & ~(|stall_out[2:0]);
                sb_q[0].dst    <= dec_dst;
                sb_q[0].wr_dst <= dec_wr_dst;
                sb_q[0].src    <= dec_src_a;
                sb_q[0].wr_src <= dec_wr_src;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: drivers push expected outputs per cycle,
// a negedge monitor pops and compares; a CNT_W=4 copy exercises counter saturation.
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_src_a_used, dec_src_b_used, dec_wr_dst, dec_wr_src;
    logic [2:0]  dec_src_a, dec_src_b, dec_dst;
    logic        mem_busy, branch_fail;
    logic [7:0]  stall_out, stall_out_s;
    logic        clear_out, clear_out_s, fetch_hold, fetch_hold_s;
    logic [1:0]  state_o, state_o_s;
    logic [15:0] stall_cycles;
    logic [3:0]  stall_cycles_s;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [15:0] exp_cnt;
    logic [3:0]  exp_cnt4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_src_a(dec_src_a), .dec_src_a_used(dec_src_a_used),
        .dec_src_b(dec_src_b), .dec_src_b_used(dec_src_b_used),
        .dec_dst(dec_dst), .dec_wr_dst(dec_wr_dst), .dec_wr_src(dec_wr_src),
        .mem_busy(mem_busy), .branch_fail(branch_fail),
        .stall_out(stall_out), .clear_out(clear_out), .fetch_hold(fetch_hold),
        .state_o(state_o), .stall_cycles(stall_cycles)
    );

    hazard_stall_controller #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_src_a(dec_src_a), .dec_src_a_used(dec_src_a_used),
        .dec_src_b(dec_src_b), .dec_src_b_used(dec_src_b_used),
        .dec_dst(dec_dst), .dec_wr_dst(dec_wr_dst), .dec_wr_src(dec_wr_src),
        .mem_busy(mem_busy), .branch_fail(branch_fail),
        .stall_out(stall_out_s), .clear_out(clear_out_s), .fetch_hold(fetch_hold_s),
        .state_o(state_o_s), .stall_cycles(stall_cycles_s)
    );

    // Monitor: one expected record per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [31:0] e, a;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {stall_out, clear_out, fetch_hold, state_o, stall_cycles, stall_cycles_s};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got stall=%h clr=%b fh=%b st=%0d cnt=%0d cnt4=%0d, want stall=%h clr=%b fh=%b st=%0d cnt=%0d cnt4=%0d",
                         n, a[31:24], a[23], a[22], a[21:20], a[19:4], a[3:0],
                         e[31:24], e[23], e[22], e[21:20], e[19:4], e[3:0]);
            end
        end
    end

    // Drive one cycle of inputs and queue the hand-computed expectation for it.
    task automatic cyc(input logic dv, input logic [2:0] sa, input logic sau,
                       input logic [2:0] sbx, input logic sbu, input logic [2:0] dst,
                       input logic wd, input logic ws, input logic mb, input logic bf,
                       input logic [7:0] es, input logic [1:0] est, input string nm);
        logic ec, efh;
        dec_valid = dv;  dec_src_a = sa;  dec_src_a_used = sau;
        dec_src_b = sbx; dec_src_b_used = sbu;
        dec_dst = dst;   dec_wr_dst = wd;  dec_wr_src = ws;
        mem_busy = mb;   branch_fail = bf;
        ec  = (est == 2'd2);
        efh = (es != 8'h00) && !bf;
        exp_q.push_back({es, ec, efh, est, exp_cnt, exp_cnt4});
        name_q.push_back(nm);
        if (es != 8'h00) begin
            if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt4 != 4'hf) exp_cnt4 = exp_cnt4 + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic mb, input logic bf, input logic [7:0] es,
                       input logic [1:0] est, input string nm);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, mb, bf, es, est, nm);
    endtask

    task automatic wr(input logic [2:0] dst, input string nm);
        cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, dst, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, nm);
    endtask

    task automatic rda(input logic [2:0] sa, input logic mb, input logic bf,
                       input logic [7:0] es, input logic [1:0] est, input string nm);
        cyc(1'b1, sa, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, mb, bf, es, est, nm);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) nop(1'b0, 1'b0, 8'h00, 2'd0, "drain");
    endtask

    task automatic do_reset();
        dec_valid = 0; dec_src_a = 0; dec_src_a_used = 0; dec_src_b = 0; dec_src_b_used = 0;
        dec_dst = 0; dec_wr_dst = 0; dec_wr_src = 0; mem_busy = 0; branch_fail = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt  = '0;
        exp_cnt4 = '0;
    endtask

    initial begin
        exp_cnt  = '0;
        exp_cnt4 = '0;
        do_reset();
        nop(0, 0, 8'h00, 2'd0, "reset_state");

        // Plain RAW on destination: walks EX -> MEM -> WB then clears.
        wr(3'd3, "add_r3");
        rda(3'd3, 0, 0, 8'h01, 2'd0, "raw_ex");
        rda(3'd3, 0, 0, 8'h02, 2'd0, "raw_mem");
        rda(3'd3, 0, 0, 8'h04, 2'd0, "raw_wb");
        rda(3'd3, 0, 0, 8'h00, 2'd0, "raw_clear");
        drain();

        // SWAP writes both dst and src_a; dependent reads via src_b.
        cyc(1, 3'd2, 1, 3'd0, 0, 3'd1, 1, 1, 0, 0, 8'h00, 2'd0, "swap");
        cyc(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0, 0, 8'h01, 2'd0, "swap_ex");
        cyc(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0, 0, 8'h02, 2'd0, "swap_mem");
        cyc(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0, 0, 8'h04, 2'd0, "swap_wb");
        cyc(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0, 0, 8'h00, 2'd0, "swap_clear");
        drain();
        cyc(1, 3'd2, 1, 3'd0, 0, 3'd1, 1, 1, 0, 0, 8'h00, 2'd0, "swap2");
        cyc(1, 3'd0, 0, 3'd2, 0, 3'd0, 0, 0, 0, 0, 8'h00, 2'd0, "src_unused");
        drain();

        // Memory wait freezes a hazard sitting in MEM.
        wr(3'd5, "add_r5");
        rda(3'd5, 0, 0, 8'h01, 2'd0, "raw_ex2");
        rda(3'd5, 1, 0, 8'h0A, 2'd0, "mem_busy_run");
        for (int i = 0; i < 3; i++) rda(3'd5, 1, 0, 8'h0A, 2'd1, "mem_wait");
        rda(3'd5, 0, 0, 8'h0A, 2'd1, "mem_release");
        rda(3'd5, 0, 0, 8'h02, 2'd0, "post_wait_mem");
        rda(3'd5, 0, 0, 8'h04, 2'd0, "post_wait_wb");
        rda(3'd5, 0, 0, 8'h00, 2'd0, "post_wait_clear");
        drain();

        // Branch fail during a hazard stall.
        wr(3'd6, "add_r6");
        rda(3'd6, 0, 0, 8'h01, 2'd0, "raw_ex3");
        rda(3'd6, 0, 1, 8'h02, 2'd0, "bf_fetch_release");
        rda(3'd6, 0, 0, 8'h10, 2'd2, "flush_1");
        rda(3'd6, 0, 0, 8'h10, 2'd2, "flush_2");
        rda(3'd6, 0, 0, 8'h00, 2'd0, "sb_emptied");
        drain();

        // Branch fail inside FLUSH reloads the counter.
        nop(0, 1, 8'h00, 2'd0, "bf_idle");
        nop(0, 1, 8'h10, 2'd2, "bf_reload");
        nop(0, 0, 8'h10, 2'd2, "reload_1");
        nop(0, 0, 8'h10, 2'd2, "reload_2");
        nop(0, 0, 8'h00, 2'd0, "reload_done");

        // FLUSH exits into MEM_WAIT when memory is busy at the end.
        nop(0, 1, 8'h00, 2'd0, "bf_b");
        nop(0, 0, 8'h10, 2'd2, "flush_b1");
        nop(1, 0, 8'h10, 2'd2, "flush_b2_busy");
        nop(0, 0, 8'h08, 2'd1, "flush_to_wait");
        nop(0, 0, 8'h00, 2'd0, "wait_done");

        // Long stall: the 4-bit counter copy must stick at 15.
        nop(1, 0, 8'h08, 2'd0, "sat_start");
        for (int i = 0; i < 20; i++) nop(1, 0, 8'h08, 2'd1, "sat_wait");
        nop(0, 0, 8'h08, 2'd1, "sat_release");
        nop(0, 0, 8'h00, 2'd0, "sat_done");

        // Reset mid-FLUSH and mid-MEM_WAIT, and with a producer in flight.
        nop(0, 1, 8'h00, 2'd0, "bf_c");
        nop(0, 0, 8'h10, 2'd2, "in_flush");
        do_reset();
        nop(0, 0, 8'h00, 2'd0, "rst_mid_flush");
        nop(1, 0, 8'h08, 2'd0, "busy_c");
        nop(1, 0, 8'h08, 2'd1, "in_wait");
        do_reset();
        nop(0, 0, 8'h00, 2'd0, "rst_mid_wait");
        wr(3'd4, "add_r4");
        do_reset();
        rda(3'd4, 0, 0, 8'h00, 2'd0, "rst_sb_empty");

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
